// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - Ethernet constants, receive FSM states and byte-wise CRC-32 step.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_END,
        ST_ABORT,
        ST_WAIT_END
    } rx_state_t;

    // Reflected CRC-32, LSB of the byte first, no final inversion.
    function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// rtl/eth_crc32_d8.sv - Byte-wise CRC-32 register with synchronous clear and enable.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= ETH_CRC_INIT;
        end else if (clear) begin
            crc <= ETH_CRC_INIT;
        end else if (enable) begin
            crc <= crc32_d8(crc, data);
        end
    end

endmodule

// File: rtl/gmii_rx_deframer.sv
// rtl/gmii_rx_deframer.sv - GMII receive deframer to 8-bit AXI-Stream; optional FCS check under GMII_RX_FCS_CHECK_EN.
module gmii_rx_deframer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_MAX = 7,
    parameter int STAT_WIDTH   = 16
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            eth_rxd,
    input  logic                  eth_rxdv,
    input  logic                  eth_rxer,
    input  logic                  axis_tready,
    output logic                  axis_tvalid,
    output logic [7:0]            axis_tdata,
    output logic                  axis_tlast,
    output logic                  axis_tuser,
    output logic [STAT_WIDTH-1:0] stat_frames_ok,
    output logic [STAT_WIDTH-1:0] stat_frames_bad
);

    rx_state_t  state;
    logic [7:0] pipe_data [4];
    logic [3:0] pipe_valid;
    logic [7:0] hold_data;
    logic       hold_valid;
    logic       error;
    logic [7:0] pre_cnt;

    logic slot_free;
    logic beat_done;
    logic is_pre;
    logic is_sfd;
    logic pre_drop;
    logic runt;
    logic frame_bad;

    assign slot_free = !axis_tvalid || axis_tready;
    assign beat_done = axis_tvalid && axis_tready && axis_tlast;
    assign is_pre    = (eth_rxd == ETH_PREAMBLE);
    assign is_sfd    = (eth_rxd == ETH_SFD);
    assign pre_drop  = (state == ST_PRE) && eth_rxdv &&
                       ((is_pre && (pre_cnt >= 8'(PREAMBLE_MAX))) || (!is_pre && !is_sfd));
    assign runt      = (state == ST_DATA) && !eth_rxdv && !hold_valid;

`ifdef GMII_RX_FCS_CHECK_EN
    logic [31:0] crc;
    logic        crc_clear;
    logic        crc_en;

    assign crc_clear = eth_rxdv && is_sfd && ((state == ST_IDLE) || (state == ST_PRE));
    assign crc_en    = eth_rxdv && (state == ST_DATA);

    eth_crc32_d8 u_crc (
        .clk    (clk),
        .reset  (reset),
        .clear  (crc_clear),
        .enable (crc_en),
        .data   (eth_rxd),
        .crc    (crc)
    );

    // The CRC is frozen outside DATA, so it stays valid while the end beat waits for the slot.
    assign frame_bad = error || (crc != ETH_CRC_RESIDUE);
`else
    assign frame_bad = error;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            pipe_data       <= '{default: 8'h00};
            pipe_valid      <= 4'b0000;
            hold_data       <= 8'h00;
            hold_valid      <= 1'b0;
            error           <= 1'b0;
            pre_cnt         <= 8'h00;
            axis_tvalid     <= 1'b0;
            axis_tdata      <= 8'h00;
            axis_tlast      <= 1'b0;
            axis_tuser      <= 1'b0;
            stat_frames_ok  <= '0;
            stat_frames_bad <= '0;
        end else begin
            if (axis_tvalid && axis_tready) begin
                axis_tvalid <= 1'b0;
            end
            stat_frames_ok  <= stat_frames_ok + STAT_WIDTH'(beat_done && !axis_tuser);
            stat_frames_bad <= stat_frames_bad + STAT_WIDTH'(beat_done && axis_tuser)
                                               + STAT_WIDTH'(pre_drop || runt);

            case (state)
                ST_IDLE: begin
                    if (eth_rxdv) begin
                        if (is_pre) begin
                            state   <= ST_PRE;
                            pre_cnt <= 8'd1;
                        end else if (is_sfd) begin
                            state      <= ST_DATA;
                            pipe_valid <= 4'b0000;
                            hold_valid <= 1'b0;
                            error      <= 1'b0;
                        end else begin
                            state <= ST_WAIT_END;
                        end
                    end
                end
                ST_PRE: begin
                    if (!eth_rxdv) begin
                        state <= ST_IDLE;
                    end else if (pre_drop) begin
                        state <= ST_WAIT_END;
                    end else if (is_pre) begin
                        pre_cnt <= pre_cnt + 8'd1;
                    end else begin
                        state      <= ST_DATA;
                        pipe_valid <= 4'b0000;
                        hold_valid <= 1'b0;
                        error      <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (eth_rxdv) begin
                        if (eth_rxer) begin
                            error <= 1'b1;
                        end
                        if (hold_valid && !slot_free) begin
                            error <= 1'b1;
                            state <= ST_ABORT;
                        end else begin
                            if (hold_valid) begin
                                axis_tvalid <= 1'b1;
                                axis_tdata  <= hold_data;
                                axis_tlast  <= 1'b0;
                                axis_tuser  <= 1'b0;
                            end
                            // Four bytes of lag behind the hold register keep the FCS off the stream.
                            hold_data    <= pipe_data[3];
                            hold_valid   <= pipe_valid[3];
                            pipe_data[3] <= pipe_data[2];
                            pipe_data[2] <= pipe_data[1];
                            pipe_data[1] <= pipe_data[0];
                            pipe_data[0] <= eth_rxd;
                            pipe_valid   <= {pipe_valid[2:0], 1'b1};
                        end
                    end else if (hold_valid) begin
                        if (slot_free) begin
                            axis_tvalid <= 1'b1;
                            axis_tdata  <= hold_data;
                            axis_tlast  <= 1'b1;
                            axis_tuser  <= frame_bad;
                            state       <= ST_IDLE;
                        end else begin
                            state <= ST_END;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_END: begin
                    if (slot_free) begin
                        axis_tvalid <= 1'b1;
                        axis_tdata  <= hold_data;
                        axis_tlast  <= 1'b1;
                        axis_tuser  <= frame_bad;
                        state       <= ST_IDLE;
                    end
                end
                ST_ABORT: begin
                    if (slot_free) begin
                        axis_tvalid <= 1'b1;
                        axis_tdata  <= 8'h00;
                        axis_tlast  <= 1'b1;
                        axis_tuser  <= 1'b1;
                        state       <= eth_rxdv ? ST_WAIT_END : ST_IDLE;
                    end
                end
                ST_WAIT_END: begin
                    if (!eth_rxdv) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// tb/tb_gmii_rx_deframer.sv - Scoreboard bench for gmii_rx_deframer with directed GMII frames.
module tb_gmii_rx_deframer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  eth_rxd;
    logic        eth_rxdv;
    logic        eth_rxer;
    logic        axis_tready;
    logic        axis_tvalid;
    logic [7:0]  axis_tdata;
    logic        axis_tlast;
    logic        axis_tuser;
    logic [15:0] stat_frames_ok;
    logic [15:0] stat_frames_bad;

    gmii_rx_deframer #(.PREAMBLE_MAX(7), .STAT_WIDTH(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .eth_rxd         (eth_rxd),
        .eth_rxdv        (eth_rxdv),
        .eth_rxer        (eth_rxer),
        .axis_tready     (axis_tready),
        .axis_tvalid     (axis_tvalid),
        .axis_tdata      (axis_tdata),
        .axis_tlast      (axis_tlast),
        .axis_tuser      (axis_tuser),
        .stat_frames_ok  (stat_frames_ok),
        .stat_frames_bad (stat_frames_bad)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       user;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      mon_b;
    logic [7:0] tx[$];
    int         tests = 0;
    int         fails = 0;
    int         exp_ok = 0;
    int         exp_bad = 0;

    logic [7:0] arp [42] = '{
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h22, 8'hAC, 8'h10, 8'hF7, 8'h89, 8'hBB,
        8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
        8'h22, 8'hAC, 8'h10, 8'hF7, 8'h89, 8'hBB, 8'h0A, 8'h00, 8'h00, 8'h01,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h6E
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit-serial reference CRC; the transmitted FCS is its complement, low byte first.
    function automatic logic [31:0] fcs_of_arp();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 42; i++) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ arp[i][j];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    always @(negedge clk) begin
        if (!reset && axis_tvalid && axis_tready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_beat: got data %0h last %0b, expected no beat", axis_tdata, axis_tlast);
            end else begin
                mon_b = exp_q.pop_front();
                check("beat_data", axis_tdata, mon_b.d);
                check("beat_last", axis_tlast, mon_b.last);
                if (mon_b.last) check("beat_user", axis_tuser, mon_b.user);
            end
        end
    end

    task automatic put(input logic [7:0] d, input logic dv, input logic er);
        eth_rxd  = d;
        eth_rxdv = dv;
        eth_rxer = er;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) put(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send(input int npre, input int n, input int er_idx);
        repeat (npre) put(8'h55, 1'b1, 1'b0);
        put(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) put(tx[i], 1'b1, i == er_idx);
    endtask

    task automatic load_tx(input logic good_fcs);
        logic [31:0] f;
        f = good_fcs ? fcs_of_arp() : 32'h0;
        tx = {};
        for (int i = 0; i < 42; i++) tx.push_back(arp[i]);
        for (int i = 0; i < 4; i++) tx.push_back(f[8*i +: 8]);
    endtask

    task automatic expect_frame(input logic user);
        beat_t b;
        for (int i = 0; i < 42; i++) begin
            b.d    = arp[i];
            b.last = (i == 41);
            b.user = (i == 41) ? user : 1'b0;
            exp_q.push_back(b);
        end
    endtask

    task automatic push_beat(input logic [7:0] d, input logic last, input logic user);
        beat_t b;
        b.d    = d;
        b.last = last;
        b.user = user;
        exp_q.push_back(b);
    endtask

    task automatic drain_and_stats();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("beats_outstanding", exp_q.size(), 0);
        check("stat_frames_ok", stat_frames_ok, exp_ok);
        check("stat_frames_bad", stat_frames_bad, exp_bad);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        eth_rxd     = 8'h00;
        eth_rxdv    = 1'b0;
        eth_rxer    = 1'b0;
        axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tvalid", axis_tvalid, 0);
        check("reset_tdata", axis_tdata, 0);
        check("reset_tlast", axis_tlast, 0);
        check("reset_tuser", axis_tuser, 0);
        check("reset_ok", stat_frames_ok, 0);
        check("reset_bad", stat_frames_bad, 0);
        reset = 1'b0;
        idle(3);

        // ARP request with zero FCS
        load_tx(1'b0);
`ifdef GMII_RX_FCS_CHECK_EN
        expect_frame(1'b1);
        exp_bad++;
`else
        expect_frame(1'b0);
        exp_ok++;
`endif
        send(7, 46, -1);
        idle(12);
        drain_and_stats();

        // Same frame with a correct FCS
        load_tx(1'b1);
        expect_frame(1'b0);
        exp_ok++;
        send(7, 46, -1);
        idle(12);
        drain_and_stats();

        // rxer on the 10th data byte
        expect_frame(1'b1);
        exp_bad++;
        send(7, 46, 9);
        idle(12);
        drain_and_stats();

        // Downstream stalled for the whole frame: one held byte, then the abort terminator
        axis_tready = 1'b0;
        push_beat(8'hFF, 1'b0, 1'b0);
        push_beat(8'h00, 1'b1, 1'b1);
        send(7, 46, -1);
        idle(3);
        axis_tready = 1'b1;
        idle(10);
        exp_bad++;
        drain_and_stats();

        // Runt: three bytes after SFD
        send(7, 3, -1);
        idle(6);
        exp_bad++;
        drain_and_stats();

        // Nine preamble bytes
        send(9, 10, -1);
        idle(6);
        exp_bad++;
        drain_and_stats();

        // Reset mid-frame, then a clean frame
        expect_frame(1'b0);
        send(7, 20, -1);
        check("pre_reset_tvalid", axis_tvalid, 1);
        reset = 1'b1;
        #1;
        check("mid_reset_tvalid", axis_tvalid, 0);
        check("mid_reset_tdata", axis_tdata, 0);
        check("mid_reset_tlast", axis_tlast, 0);
        check("mid_reset_tuser", axis_tuser, 0);
        check("mid_reset_ok", stat_frames_ok, 0);
        check("mid_reset_bad", stat_frames_bad, 0);
        exp_q.delete();
        exp_ok   = 0;
        exp_bad  = 0;
        eth_rxdv = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);
        expect_frame(1'b0);
        exp_ok++;
        send(7, 46, -1);
        idle(12);
        drain_and_stats();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
